bus_copy_master: RTL and testbench



---
 rtl/bus_copy_master.sv | 105 ++++++++++
 tb/tb_bus_copy_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_master.sv
// Bus master that copies a block of words from one address range to another.
// Each word takes three cycles: present the read address, capture the data, write it back.
module bus_copy_master #(
    parameter int unsigned P_ADDR_W = 8,
    parameter int unsigned P_DATA_W = 32,
    parameter int unsigned P_LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [P_ADDR_W-1:0] srcBase,
    input  logic [P_ADDR_W-1:0] dstBase,
    input  logic [P_LEN_W-1:0]  len,
    output logic                busy,
    output logic                done,
    output logic [P_ADDR_W-1:0] addr,
    output logic                we,
    output logic [P_DATA_W-1:0] dataM2S,
    input  logic [P_DATA_W-1:0] dataS2M
);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [P_LEN_W-1:0]  idx_q, idx_d, len_q, len_d, idx_inc;
    logic [P_ADDR_W-1:0] src_q, src_d, dst_q, dst_d, idx_addr;
    logic [P_DATA_W-1:0] buf_q, buf_d;

    assign idx_inc  = idx_q + P_LEN_W'(1);
    // Address sums wrap naturally at the address width.
    assign idx_addr = P_ADDR_W'(idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    src_d   = srcBase;
                    dst_d   = dstBase;
                    len_d   = len;
                    idx_d   = '0;
                    state_d = (len == '0) ? StDone : StRead;
                end
            end
            StRead:    state_d = StCapture;
            StCapture: begin
                buf_d   = dataS2M;
                state_d = StWrite;
            end
            StWrite: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? StDone : StRead;
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs depend only on registered state, never on start or dataS2M.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        addr    = '0;
        we      = 1'b0;
        dataM2S = '0;
        case (state_q)
            StRead, StCapture: begin
                busy = 1'b1;
                addr = src_q + idx_addr;
            end
            StWrite: begin
                busy    = 1'b1;
                addr    = dst_q + idx_addr;
                we      = 1'b1;
                dataM2S = buf_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master with a registered-read memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_copy_master;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, we;
    logic [7:0]  srcBase, dstBase, len, addr;
    logic [31:0] dataM2S, dataS2M;

    logic [31:0] mem [256];
    logic        pl_we;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    int n_checks = 0;
    int n_fail   = 0;
    int lat, wn, bn, dn;

    bus_copy_master #(.P_ADDR_W(8), .P_DATA_W(32), .P_LEN_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .srcBase (srcBase),
        .dstBase (dstBase),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .addr    (addr),
        .we      (we),
        .dataM2S (dataM2S),
        .dataS2M (dataS2M)
    );

    always #5 clk = ~clk;

    // Memory: write on the edge where we=1, read data valid the cycle after the address.
    always @(posedge clk) begin
        if (we) mem[addr] <= dataM2S;
        else if (pl_we) mem[pl_addr] <= pl_data;
        dataS2M <= mem[addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = v;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Starts a copy and watches it for budget cycles; optionally fires a second start at
    // cycle second_at. lat is the first cycle (counted from the start cycle) with done high.
    task automatic copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                        input int budget, input int second_at,
                        output int lat_o, output int we_n, output int busy_n,
                        output int done_n);
        lat_o = -1; we_n = 0; busy_n = 0; done_n = 0;
        @(negedge clk);
        srcBase = s; dstBase = d; len = l; start = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0; srcBase = ~s; dstBase = ~d; len = l + 8'd1;
            end
            if (second_at != 0 && n == second_at) begin
                start = 1'b1; srcBase = 8'h50; dstBase = 8'h70; len = 8'd1;
            end
            if (second_at != 0 && n == second_at + 1) start = 1'b0;
            if (we) we_n++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat_o < 0) lat_o = n;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        srcBase = '0; dstBase = '0; len = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_addr", {24'b0, addr}, 32'd0);
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_data", dataM2S, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h20, 32'h0);
        copy(8'h10, 8'h20, 8'd1, 10, 0, lat, wn, bn, dn);
        check("single_data", mem[8'h20], 32'hDEADBEEF);
        check("single_lat", lat, 32'd4);
        check("single_we", wn, 32'd1);
        check("single_busy", bn, 32'd3);
        check("single_done", dn, 32'd1);

        // Block copy
        for (int k = 0; k < 4; k++) preload(8'(k), 32'(k + 1));
        for (int k = 0; k < 4; k++) preload(8'h80 + 8'(k), 32'hFFFF_FFFF);
        copy(8'h00, 8'h80, 8'd4, 20, 0, lat, wn, bn, dn);
        for (int k = 0; k < 4; k++) check("block_data", mem[8'h80 + 8'(k)], 32'(k + 1));
        check("block_lat", lat, 32'd13);
        check("block_busy", bn, 32'd12);
        check("block_we", wn, 32'd4);

        // Source range wraps past the top of the address space
        preload(8'hFE, 32'hAAAA_0001);
        preload(8'hFF, 32'hBBBB_0002);
        preload(8'h00, 32'hCCCC_0003);
        copy(8'hFE, 8'h40, 8'd3, 16, 0, lat, wn, bn, dn);
        check("wrap_w0", mem[8'h40], 32'hAAAA_0001);
        check("wrap_w1", mem[8'h41], 32'hBBBB_0002);
        check("wrap_w2", mem[8'h42], 32'hCCCC_0003);
        check("wrap_lat", lat, 32'd10);

        // Zero length
        copy(8'h10, 8'h20, 8'd0, 6, 0, lat, wn, bn, dn);
        check("len0_lat", lat, 32'd1);
        check("len0_busy", bn, 32'd0);
        check("len0_we", wn, 32'd0);
        check("len0_done", dn, 32'd1);

        // Second start during a copy is dropped
        preload(8'h30, 32'h0000_0011);
        preload(8'h31, 32'h0000_0022);
        preload(8'h50, 32'h0000_0055);
        preload(8'h60, 32'h0);
        preload(8'h61, 32'h0);
        preload(8'h70, 32'h0);
        copy(8'h30, 8'h60, 8'd2, 20, 2, lat, wn, bn, dn);
        check("ign_w0", mem[8'h60], 32'h0000_0011);
        check("ign_w1", mem[8'h61], 32'h0000_0022);
        check("ign_other", mem[8'h70], 32'h0);
        check("ign_done", dn, 32'd1);
        check("ign_lat", lat, 32'd7);
        check("ign_we", wn, 32'd2);

        // Overlapping ranges with dst = src+1 smear the first word forward
        preload(8'h90, 32'h7);
        preload(8'h91, 32'h8);
        preload(8'h92, 32'h9);
        preload(8'h93, 32'h0);
        copy(8'h90, 8'h91, 8'd3, 14, 0, lat, wn, bn, dn);
        check("ovl_w1", mem[8'h91], 32'h7);
        check("ovl_w2", mem[8'h92], 32'h7);
        check("ovl_w3", mem[8'h93], 32'h7);

        // Reset during the write of word 1
        for (int k = 0; k < 4; k++) preload(8'hA0 + 8'(k), 32'hA000_0000 + 32'(k));
        for (int k = 0; k < 4; k++) preload(8'hB0 + 8'(k), 32'h5A5A_5A5A);
        @(negedge clk);
        srcBase = 8'hA0; dstBase = 8'hB0; len = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_pre_we", {31'b0, we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", {31'b0, we}, 32'd0);
        check("mid_rst_addr", {24'b0, addr}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dn = 0; wn = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done) dn++;
            if (we) wn++;
        end
        check("mid_no_done", dn, 32'd0);
        check("mid_no_we", wn, 32'd0);
        check("mid_w0", mem[8'hB0], 32'hA000_0000);
        check("mid_w1", mem[8'hB1], 32'h5A5A_5A5A);

        // First start after reset works normally
        preload(8'hC0, 32'h0);
        copy(8'hA2, 8'hC0, 8'd1, 10, 0, lat, wn, bn, dn);
        check("post_data", mem[8'hC0], 32'hA000_0002);
        check("post_lat", lat, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
